// File: rtl/xain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xain_pkg : shared types and constants for the SDRAM ch3 arbiter      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package xain_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROM_XFER = 3'd1,
    BG2_XFER = 3'd2,
    LOCAL    = 3'd3,
    DONE     = 3'd4
  } ch3_state_t;

  localparam logic [15:0] CH3_DUMMY_DATA      = 16'h0000;
  localparam int unsigned CH3_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/sdr_ch3_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdr_ch3_arbiter : registered ROM-write / BG2-read arbiter for ch3    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sdr_ch3_arbiter
  import xain_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CH3_TIMEOUT_DEFAULT,
  parameter logic [15:0] DUMMY_DATA     = CH3_DUMMY_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        download,
  input  logic        dbg_mask,
  input  logic [24:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic [1:0]  rom_be,
  input  logic        rom_req,
  output logic        rom_rdy,
  input  logic [24:0] bg2_addr,
  input  logic        bg2_req,
  output logic [15:0] bg2_dout,
  output logic        bg2_rdy,
  output logic [23:0] ch_addr,
  output logic [15:0] ch_din,
  output logic [1:0]  ch_be,
  output logic        ch_rnw,
  output logic        ch_req,
  input  logic [15:0] ch_dout,
  input  logic        ch_ready,
  output logic        timeout_err
);

  localparam int unsigned      c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  ch3_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_rom_owner;
  logic               w_unused_addr_lsb;

  // Byte-address LSBs are dropped when forming the SDRAM word address.
  assign w_unused_addr_lsb = rom_addr[0] ^ bg2_addr[0];
  assign w_rom_owner       = (r_state == ROM_XFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      ch_addr     <= '0;
      ch_din      <= '0;
      ch_be       <= '0;
      ch_rnw      <= 1'b1;
      ch_req      <= 1'b0;
      rom_rdy     <= 1'b0;
      bg2_rdy     <= 1'b0;
      bg2_dout    <= '0;
      timeout_err <= 1'b0;
    end else begin
      rom_rdy <= 1'b0;
      bg2_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (download && rom_req) begin
            r_state <= ROM_XFER;
            ch_addr <= rom_addr[24:1];
            ch_din  <= rom_data;
            ch_be   <= rom_be;
            ch_rnw  <= 1'b0;
            ch_req  <= 1'b1;
          end else if (bg2_req && (download || dbg_mask)) begin
            r_state <= LOCAL;
          end else if (bg2_req) begin
            r_state <= BG2_XFER;
            ch_addr <= bg2_addr[24:1];
            ch_rnw  <= 1'b1;
            ch_req  <= 1'b1;
          end
        end
        ROM_XFER, BG2_XFER: begin
          r_cnt <= r_cnt + c_cnt_one;
          // A ready arriving on the final allowed cycle still counts as success.
          if (ch_ready) begin
            ch_req  <= 1'b0;
            r_state <= DONE;
            rom_rdy <= w_rom_owner;
            bg2_rdy <= !w_rom_owner;
            if (!w_rom_owner) begin
              bg2_dout <= ch_dout;
            end
          end else if (r_cnt == c_cnt_last) begin
            ch_req      <= 1'b0;
            bg2_dout    <= DUMMY_DATA;
            timeout_err <= 1'b1;
            r_state     <= DONE;
            rom_rdy     <= w_rom_owner;
            bg2_rdy     <= !w_rom_owner;
          end
        end
        LOCAL: begin
          bg2_dout <= DUMMY_DATA;
          bg2_rdy  <= 1'b1;
          r_state  <= DONE;
        end
        // rdy is high for this one cycle; the extra IDLE hop keeps a held req from re-issuing.
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdr_ch3_arbiter.sv
`default_nettype none
// Bench for sdr_ch3_arbiter: directed vector table, random episodes vs a
// timing model, and a reset-during-transfer sequence.
module tb_sdr_ch3_arbiter;

  localparam int T_OUT  = 8;
  localparam int BUDGET = 18;

  logic        clk = 1'b0;
  logic        reset;
  logic        download, dbg_mask;
  logic [24:0] rom_addr, bg2_addr;
  logic [15:0] rom_data, bg2_dout, ch_din, ch_dout;
  logic [1:0]  rom_be, ch_be;
  logic        rom_req, rom_rdy, bg2_req, bg2_rdy;
  logic [23:0] ch_addr;
  logic        ch_rnw, ch_req, ch_ready, timeout_err;

  always #5 clk = ~clk;

  sdr_ch3_arbiter #(.TIMEOUT_CYCLES(T_OUT), .DUMMY_DATA(16'h0000)) dut (
    .clk(clk), .reset(reset), .download(download), .dbg_mask(dbg_mask),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_be(rom_be), .rom_req(rom_req),
    .rom_rdy(rom_rdy), .bg2_addr(bg2_addr), .bg2_req(bg2_req), .bg2_dout(bg2_dout),
    .bg2_rdy(bg2_rdy), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be),
    .ch_rnw(ch_rnw), .ch_req(ch_req), .ch_dout(ch_dout), .ch_ready(ch_ready),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    bit          dl, mask, rreq, breq, flip;
    logic [24:0] raddr, baddr;
    logic [15:0] rdata, cdout;
    logic [1:0]  rbe;
    int          lat;       // ch_ready on the lat-th ch_req cycle; 0 = never
    int          e_rom_t, e_bg2_t, e_grants, e_reqc;
    logic [23:0] e_addr;
    logic        e_rnw;
    logic [15:0] e_dout;
    logic        e_terr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_terr;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic add(input bit dl, mask, rreq, breq, input logic [24:0] raddr,
                     input logic [15:0] rdata, input logic [1:0] rbe, input logic [24:0] baddr,
                     input int lat, input logic [15:0] cdout, input bit flip,
                     input int e_rom_t, e_bg2_t, e_grants, e_reqc, input logic [23:0] e_addr,
                     input logic e_rnw, input logic [15:0] e_dout, input logic e_terr);
    vec_t v;
    v = '0;
    v.dl = dl; v.mask = mask; v.rreq = rreq; v.breq = breq; v.flip = flip;
    v.raddr = raddr; v.rdata = rdata; v.rbe = rbe; v.baddr = baddr;
    v.lat = lat; v.cdout = cdout;
    v.e_rom_t = e_rom_t; v.e_bg2_t = e_bg2_t; v.e_grants = e_grants; v.e_reqc = e_reqc;
    v.e_addr = e_addr; v.e_rnw = e_rnw; v.e_dout = e_dout; v.e_terr = e_terr;
    tbl.push_back(v);
  endtask

  // Timing model: cycle numbers count negedges after the request is presented.
  task automatic model(inout vec_t v);
    int  eff, start;
    bit  to;
    to    = (v.lat == 0) || (v.lat > T_OUT);
    eff   = to ? T_OUT : v.lat;
    start = 0;
    v.e_rom_t = 0; v.e_bg2_t = 0; v.e_grants = 0; v.e_reqc = 0;
    v.e_addr = '0; v.e_rnw = 1'b1; v.e_dout = 16'h0000;
    if (v.dl) begin
      if (v.rreq) begin
        v.e_rom_t = eff + 1; v.e_grants = 1; v.e_reqc = eff;
        v.e_addr = v.raddr[24:1]; v.e_rnw = 1'b0;
        start = v.e_rom_t + 1;
        if (to) m_terr = 1'b1;
      end
      if (v.breq) v.e_bg2_t = start + 2;
    end else if (v.breq) begin
      if (v.mask) begin
        v.e_bg2_t = 2;
      end else begin
        v.e_bg2_t = eff + 1; v.e_grants = 1; v.e_reqc = eff;
        v.e_addr = v.baddr[24:1]; v.e_rnw = 1'b1;
        v.e_dout = to ? 16'h0000 : v.cdout;
        if (to) m_terr = 1'b1;
      end
    end
    v.e_terr = m_terr;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rom_t, bg2_t, rom_n, bg2_n, grants, reqc, stab_err;
    logic [23:0] cap_addr;
    logic [15:0] cap_din, got_dout;
    logic [1:0]  cap_be;
    logic        cap_rnw, prev_req;
    rom_t = 0; bg2_t = 0; rom_n = 0; bg2_n = 0; grants = 0; reqc = 0; stab_err = 0;
    cap_addr = '0; cap_din = '0; cap_be = '0; cap_rnw = 1'b0; got_dout = '0; prev_req = 1'b0;
    @(negedge clk);
    download = v.dl; dbg_mask = v.mask;
    rom_addr = v.raddr; rom_data = v.rdata; rom_be = v.rbe; rom_req = v.rreq;
    bg2_addr = v.baddr; bg2_req = v.breq; ch_ready = 1'b0; ch_dout = 16'h0000;
    for (int t = 1; t <= BUDGET; t++) begin
      @(negedge clk);
      ch_ready = 1'b0;
      if (ch_req) begin
        if (!prev_req) begin
          grants++;
          cap_addr = ch_addr; cap_din = ch_din; cap_be = ch_be; cap_rnw = ch_rnw;
        end else if ({ch_addr, ch_din, ch_be, ch_rnw} != {cap_addr, cap_din, cap_be, cap_rnw}) begin
          stab_err++;
        end
        reqc++;
        if (reqc == v.lat) begin
          ch_ready = 1'b1;
          ch_dout  = v.cdout;
        end
      end
      prev_req = ch_req;
      if (rom_rdy) begin
        rom_n++;
        if (rom_t == 0) rom_t = t;
      end
      if (bg2_rdy) begin
        bg2_n++;
        if (bg2_t == 0) begin bg2_t = t; got_dout = bg2_dout; end
      end
      // Requesters keep req high one cycle past rdy to exercise the re-issue guard.
      if (rom_t != 0 && t == rom_t + 1) rom_req = 1'b0;
      if (bg2_t != 0 && t == bg2_t + 1) bg2_req = 1'b0;
      if (v.flip && t == 2) begin download = ~download; dbg_mask = ~dbg_mask; end
    end
    rom_req = 1'b0; bg2_req = 1'b0; ch_ready = 1'b0;
    @(negedge clk);
    chk("rom_rdy_cycle", idx, rom_t, v.e_rom_t);
    chk("rom_rdy_pulses", idx, rom_n, (v.e_rom_t != 0) ? 1 : 0);
    chk("bg2_rdy_cycle", idx, bg2_t, v.e_bg2_t);
    chk("bg2_rdy_pulses", idx, bg2_n, (v.e_bg2_t != 0) ? 1 : 0);
    chk("ch_req_grants", idx, grants, v.e_grants);
    chk("ch_req_cycles", idx, reqc, v.e_reqc);
    chk("ch_stable", idx, stab_err, 0);
    chk("timeout_err", idx, {31'd0, timeout_err}, {31'd0, v.e_terr});
    if (v.e_grants != 0) begin
      chk("ch_addr", idx, {8'd0, cap_addr}, {8'd0, v.e_addr});
      chk("ch_rnw", idx, {31'd0, cap_rnw}, {31'd0, v.e_rnw});
      if (!v.e_rnw) begin
        chk("ch_din", idx, {16'd0, cap_din}, {16'd0, v.rdata});
        chk("ch_be", idx, {30'd0, cap_be}, {30'd0, v.rbe});
      end
    end
    if (v.e_bg2_t != 0) chk("bg2_dout", idx, {16'd0, got_dout}, {16'd0, v.e_dout});
  endtask

  initial begin
    int w, late_rdy, late_req;
    vec_t v;
    reset = 1'b1; download = 1'b0; dbg_mask = 1'b0;
    rom_addr = '0; rom_data = '0; rom_be = '0; rom_req = 1'b0;
    bg2_addr = '0; bg2_req = 1'b0; ch_dout = '0; ch_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rom_rdy", 100, {31'd0, rom_rdy}, 0);
    chk("rst_bg2_rdy", 100, {31'd0, bg2_rdy}, 0);
    chk("rst_bg2_dout", 100, {16'd0, bg2_dout}, 0);
    chk("rst_ch_addr", 100, {8'd0, ch_addr}, 0);
    chk("rst_ch_din", 100, {16'd0, ch_din}, 0);
    chk("rst_ch_be", 100, {30'd0, ch_be}, 0);
    chk("rst_ch_rnw", 100, {31'd0, ch_rnw}, 1);
    chk("rst_ch_req", 100, {31'd0, ch_req}, 0);
    chk("rst_timeout_err", 100, {31'd0, timeout_err}, 0);
    reset = 1'b0;

    //  dl m rr br raddr         rdata     rbe    baddr          lat cdout  flip rom_t bg2_t gr reqc e_addr      rnw dout      terr
    add(1, 0, 1, 0, 25'h000102, 16'hA55A, 2'b11, 25'h0000000, 6, 16'h0000, 0, 7, 0, 1, 6, 24'h000081, 0, 16'h0000, 0);
    add(0, 0, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h100000, 4, 16'h1234, 0, 0, 5, 1, 4, 24'h080000, 1, 16'h1234, 0);
    add(1, 0, 1, 1, 25'h0003FF, 16'h0F0F, 2'b01, 25'h000500, 3, 16'h7777, 0, 4, 7, 1, 3, 24'h0001FF, 0, 16'h0000, 0);
    add(0, 1, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h000200, 2, 16'h5555, 0, 0, 2, 0, 0, 24'h000000, 1, 16'h0000, 0);
    add(0, 0, 1, 0, 25'h000010, 16'h1111, 2'b10, 25'h0000000, 2, 16'h0000, 0, 0, 0, 0, 0, 24'h000000, 0, 16'h0000, 0);
    add(1, 0, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h000300, 2, 16'h9999, 0, 0, 2, 0, 0, 24'h000000, 1, 16'h0000, 0);
    add(0, 0, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h0000FE, 8, 16'hC0DE, 0, 0, 9, 1, 8, 24'h00007F, 1, 16'hC0DE, 0);
    add(0, 0, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h1FFFFFF, 0, 16'hFFFF, 0, 0, 9, 1, 8, 24'hFFFFFF, 1, 16'h0000, 1);
    add(1, 0, 1, 0, 25'h0ABCDE, 16'h3C3C, 2'b10, 25'h0000000, 5, 16'h0000, 1, 6, 0, 1, 5, 24'h055E6F, 0, 16'h0000, 1);
    add(0, 0, 0, 1, 25'h0000000, 16'h0000, 2'b00, 25'h000042, 3, 16'hBEEF, 1, 0, 4, 1, 3, 24'h000021, 1, 16'hBEEF, 1);
    add(1, 0, 1, 0, 25'h000004, 16'h0001, 2'b01, 25'h0000000, 0, 16'h0000, 0, 9, 0, 1, 8, 24'h000002, 0, 16'h0000, 1);
    foreach (tbl[i]) run_vec(i, tbl[i]);

    m_terr = tbl[tbl.size() - 1].e_terr;
    for (int i = 0; i < 40; i++) begin
      v = '0;
      v.dl    = 1'($urandom_range(0, 1));
      v.mask  = 1'($urandom_range(0, 1));
      v.rreq  = 1'($urandom_range(0, 1));
      v.breq  = 1'($urandom_range(0, 1));
      v.raddr = 25'($urandom);
      v.baddr = 25'($urandom);
      v.rdata = 16'($urandom);
      v.cdout = 16'($urandom);
      v.rbe   = 2'($urandom_range(0, 3));
      v.lat   = $urandom_range(0, 11);
      v.flip  = ((v.dl && (v.rreq ^ v.breq)) || (!v.dl && v.breq && !v.rreq)) && ($urandom_range(0, 1) == 1);
      model(v);
      run_vec(200 + i, v);
    end

    // Reset in the middle of a BG2 read, followed by a stale ch_ready.
    @(negedge clk);
    download = 1'b0; dbg_mask = 1'b0; bg2_addr = 25'h0ABCDE; bg2_req = 1'b1; ch_ready = 1'b0;
    w = 0;
    while (!ch_req && w < 10) begin @(negedge clk); w++; end
    chk("rstseq_grant_seen", 300, {31'd0, ch_req}, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstseq_ch_req", 300, {31'd0, ch_req}, 0);
    chk("rstseq_bg2_rdy", 300, {31'd0, bg2_rdy}, 0);
    chk("rstseq_bg2_dout", 300, {16'd0, bg2_dout}, 0);
    chk("rstseq_ch_rnw", 300, {31'd0, ch_rnw}, 1);
    chk("rstseq_timeout_err", 300, {31'd0, timeout_err}, 0);
    reset = 1'b0; bg2_req = 1'b0; ch_ready = 1'b1; ch_dout = 16'hDEAD;
    @(negedge clk);
    ch_ready = 1'b0;
    late_rdy = 0; late_req = 0;
    repeat (4) begin
      @(negedge clk);
      if (bg2_rdy || rom_rdy) late_rdy++;
      if (ch_req) late_req++;
    end
    chk("rstseq_late_rdy", 300, late_rdy, 0);
    chk("rstseq_late_req", 300, late_req, 0);
    m_terr = 1'b0;
    v = '0;
    v.mask = 1'b1; v.breq = 1'b1; v.baddr = 25'h000777; v.lat = 2;
    model(v);
    run_vec(301, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdr_ch3_arbiter.md
Name: sdr_ch3_arbiter

Overview:
- Registered arbiter that shares SDRAM channel 3 between the ROM-download write path and the BG2 tile-fetch read path.
- Replaces the combinational ch3 mux in the core top level. Adds a one-request-at-a-time handshake, download-phase gating, debug masking and a stuck-channel timeout.
- Sits between rom_loader / the BG2 fetcher and the sdram controller's ch3 port, in the SDRAM clock domain.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transfer may wait for ch_ready before it is forcibly completed.
- DUMMY_DATA, 16'h0000: data returned for BG2 reads that are answered locally (during download, masked, or timed out).

Ports:
- clk  in  1  SDRAM-domain clock
- reset  in  1  synchronous, active-high reset
- download  in  1  ROM download in progress (ioctl_download && ioctl_index==0)
- dbg_mask  in  1  debug: suppress BG2 SDRAM traffic
- rom_addr  in  25  byte address
- rom_data  in  16  write data
- rom_be  in  2  byte enables
- rom_req  in  1  level request
- rom_rdy  out  1  1-cycle completion pulse
- bg2_addr  in  25  byte address
- bg2_req  in  1  level request
- bg2_dout  out  16  read data, valid with bg2_rdy
- bg2_rdy  out  1  1-cycle completion pulse
- ch_addr  out  24  word address to sdram ch3
- ch_din  out  16  write data
- ch_be  out  2  byte enables
- ch_rnw  out  1  1=read, 0=write
- ch_req  out  1  held until ch_ready
- ch_dout  in  16  read data from sdram
- ch_ready  in  1  1-cycle completion pulse from sdram
- timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset values: all outputs 0, ch_rnw=1, state IDLE, timeout counter 0. Reset mid-transfer drops ch_req the next cycle. A late ch_ready that arrives while in IDLE is ignored.
- Requester rule: hold req and addr/data stable until its rdy pulse. Req may be high again at earliest 1 cycle after rdy.
- States are IDLE, ROM_XFER, BG2_XFER, LOCAL, DONE.
- IDLE, download=1:
  - rom_req=1 → ROM_XFER. Latch ch_addr=rom_addr[24:1], ch_din, ch_be, ch_rnw=0, ch_req=1 on the next edge.
  - bg2_req=1 → LOCAL.
- IDLE, download=0:
  - bg2_req=1 and dbg_mask=0 → BG2_XFER with ch_rnw=1.
  - bg2_req=1 and dbg_mask=1 → LOCAL.
  - rom_req is ignored; rom_rdy is never asserted.
- ROM_XFER / BG2_XFER:
  - Counter increments each cycle.
  - ch_ready=1 → ch_req=0, latch ch_dout into bg2_dout (BG2 only), → DONE.
  - Counter reaching TIMEOUT_CYCLES without ch_ready → ch_req=0, bg2_dout=DUMMY_DATA, timeout_err=1, → DONE.
- LOCAL: bg2_dout=DUMMY_DATA → DONE.
- DONE: assert the owner's rdy for exactly 1 cycle → IDLE. This guarantees a 1-cycle gap so a still-high req is never re-issued.
- Latency:
  - req sampled at edge N → ch_req high after N+1.
  - ch_ready at edge M → rdy high in cycle M+1.
  - Earliest next grant samples at M+2.
  - Local answer: rdy 2 cycles after req.
- download or dbg_mask changing mid-transfer: the in-flight transfer completes normally. The new policy applies at the next IDLE.
- Simultaneous rom_req and bg2_req with download=1: ROM is granted; BG2 is answered locally next.
- ch_addr, ch_din, ch_be and ch_rnw stay constant while ch_req=1.
- rom_addr[0] and bg2_addr[0] are ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1). Counter clears on entry to IDLE.
- timeout_err clears only on reset.

Decomposition:
- xain_pkg holds:
  - the ch3_state_t enum (IDLE, ROM_XFER, BG2_XFER, LOCAL, DONE);
  - CH3_DUMMY_DATA;
  - CH3_TIMEOUT_DEFAULT.
- No sub-module: a single FSM plus a counter.

Test Plan:
- download=1, rom_req with addr 25'h000102, data 16'hA55A, be 2'b11; sdram ready 6 cycles after ch_req → ch_addr=24'h000081, ch_rnw=0; rom_rdy pulses once, 1 cycle after ch_ready; no second ch_req while rom_req still high.
- download=0, bg2_req with addr 25'h100000; ch_dout=16'h1234 on ch_ready → ch_addr=24'h080000, ch_rnw=1; bg2_dout=16'h1234 together with a 1-cycle bg2_rdy.
- download=1 and bg2_req=1 together with rom_req=1 → ROM transfer first; bg2_rdy with 16'h0000 follows, and ch_req is never raised for BG2.
- dbg_mask=1, bg2_req → bg2_rdy 2 cycles later, dout 16'h0000, ch_req stays 0.
- TIMEOUT_CYCLES=8, ch_ready never asserted → ch_req drops after 8 cycles; bg2_rdy pulses with dout 16'h0000; timeout_err=1 and stays 1 until reset.
- Reset asserted during BG2_XFER, then a late ch_ready → ch_req=0 the cycle after reset; no rdy pulse; FSM in IDLE.
